mod_down_counter: RTL and testbench
===================================

Name: mod_down_counter

Overview:
- Selectable-modulus down counter; complement to the team's existing up-counting mode counter.
- Same 2-bit select encoding: hold / mod-4 / mod-8 / mod-16.
- Adds a synchronous parallel load, a count enable, a one-cycle terminal-count (wrap) pulse and a saturating wrap tally.
- Used as a countdown timer / divider alongside the up counter, which shares the same select bus.

Parameters:
- WIDTH, 4, count width in bits; the select-derived maxima below assume 4.
- TALLY_W, 8, width of the saturating wrap tally.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- select  input  2  mode: 00 hold, 01 max 3, 10 max 7, 11 max 15
- load  input  1  synchronous load strobe; highest priority after reset
- load_val  input  WIDTH  value to load
- enable  input  1  count enable; ignored when select=00
- count  output  WIDTH  current count (registered)
- tc  output  1  terminal-count pulse (registered)
- wraps  output  TALLY_W  number of wraps since last load or reset, saturating

Behaviour:
- One clock domain. Reset is asynchronous and active-low (rst_n); there is one clock (clk).
- Reset: count=0, tc=0, wraps=0, applied immediately on rst_n low, independent of clk. On release, the first active edge behaves normally.
- max(select): 00 -> 15 (load mask only), 01 -> 3, 10 -> 7, 11 -> 15.
- Per rising edge, priority order:
  1. load=1: count <= load_val & max(select); wraps <= 0; tc <= 0. Load is honoured in every select mode, including 00.
  2. select=00 or enable=0: count holds, wraps holds, tc <= 0.
  3. count > max(select), which only occurs after the select range shrinks: count <= max(select); tc <= 0; no tally increment.
  4. count == 0: count <= max(select); tc <= 1; wraps <= wraps+1, saturating at 2^TALLY_W-1.
  5. Otherwise: count <= count-1; tc <= 0.
- Latency:
  - All outputs are registered, with one-cycle latency from inputs.
  - tc is high exactly in the cycle where count shows max after a wrap.
  - tc never stays high two consecutive cycles unless count is at 0 with max=0, which is impossible because the minimum max is 3.
- A select change mid-run takes effect on the next enabled edge; no state is lost except via the clamp in rule 3.
- load and a wrap condition on the same edge: load wins, and there is no tc and no tally increment.
- The wraps tally holds at all-ones once saturated; only load or reset clears it.
- Arithmetic is unsigned modulo 2^WIDTH. Decrement never underflows because the 0 case is caught first.

Decomposition:
- Shared package (also consumed by the up counter):
  - select encoding constants SEL_HOLD=2'b00, SEL_MOD4=2'b01, SEL_MOD8=2'b10, SEL_MOD16=2'b11.
  - WIDTH default.
  - A function returning max(select).
- One small combinational sub-module, mod_limit_decode (select -> max), is natural. It is shared with the up counter so both ends agree on limits.
- Next-state logic and the tally live in mod_down_counter.

Test Plan:
- Reset check: assert rst_n=0 mid-count with count=5, between clock edges -> count=0, tc=0, wraps=0 immediately. After release with select=01, enable=1: count 0 -> 3 on the first edge with tc=1 and wraps=1.
- Mod-4 wrap: select=01, load 2, then enable for 6 edges -> count 1,0,3,2,1,0 with tc high only on the edge showing 3; wraps=1.
- Range shrink clamp: select=11, load 13, then switch to select=10 with enable -> count=7, tc=0, wraps unchanged. Next edges show 6,5.
- Load versus wrap collision: select=10, count=0, enable=1, load=1 with load_val=12 on the same edge -> count=4 (12 & 7), tc=0, wraps=0.
- Hold modes: select=00 with enable=1 for 10 edges -> count constant, tc=0. Then load_val=9 with load=1 under select=00 -> count=9.
- Tally saturation: select=01, enable held for 1100 edges from count=0 -> wraps reaches 255 and stays; tc keeps pulsing every 4 cycles.

Source files
------------

// File: rtl/mod_down_counter_pkg.sv
// Shared definitions for the mode counters: select encoding, default width and
// the select-to-maximum mapping used by both the up and down counters.
package mod_down_counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    SEL_HOLD  = 2'b00,
    SEL_MOD4  = 2'b01,
    SEL_MOD8  = 2'b10,
    SEL_MOD16 = 2'b11
  } sel_e;

  // Hold mode reports 15 so that a load under hold is masked to the full range.
  function automatic logic [DEFAULT_WIDTH-1:0] max_for_sel(input logic [1:0] sel);
    logic [DEFAULT_WIDTH-1:0] max_val;
    max_val = 4'd15;
    case (sel)
      SEL_MOD4:  max_val = 4'd3;
      SEL_MOD8:  max_val = 4'd7;
      SEL_MOD16: max_val = 4'd15;
      default:   max_val = 4'd15;
    endcase
    return max_val;
  endfunction

endpackage

// File: rtl/mod_down_counter_if.sv
// Control and status bundle of the selectable-modulus down counter.
interface mod_down_counter_if #(
  parameter int WIDTH   = 4,
  parameter int TALLY_W = 8
);

  logic [1:0]         select;
  logic               load;
  logic [WIDTH-1:0]   load_val;
  logic               enable;
  logic [WIDTH-1:0]   count;
  logic               tc;
  logic [TALLY_W-1:0] wraps;

  modport master (
    output select, load, load_val, enable,
    input  count, tc, wraps
  );

  modport slave (
    input  select, load, load_val, enable,
    output count, tc, wraps
  );

endinterface

// File: rtl/mod_limit_decode.sv
// Combinational select -> maximum count decoder, shared with the up counter so
// both directions agree on the wrap limits.
module mod_limit_decode
  import mod_down_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [1:0]       sel_i,
  output logic [WIDTH-1:0] max_o
);

  assign max_o = WIDTH'(max_for_sel(sel_i));

endmodule

// File: rtl/mod_down_counter.sv
// Selectable-modulus down counter with synchronous load, count enable, a
// registered terminal-count pulse and a saturating wrap tally.
module mod_down_counter
  import mod_down_counter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TALLY_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mod_down_counter_if.slave bus
);

  logic [WIDTH-1:0]   max_val;
  logic [WIDTH-1:0]   count_q, count_d;
  logic               tc_q, tc_d;
  logic [TALLY_W-1:0] wraps_q, wraps_d;

  mod_limit_decode #(.WIDTH(WIDTH)) u_limit (
    .sel_i (bus.select),
    .max_o (max_val)
  );

  // NOTE: every output of this block gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    count_d = count_q;
    wraps_d = wraps_q;
    tc_d    = 1'b0;
    if (bus.load) begin
      count_d = bus.load_val & max_val;
      wraps_d = '0;
    end else if (bus.select == SEL_HOLD || !bus.enable) begin
      count_d = count_q;
    end else if (count_q > max_val) begin
      // Only reachable after the select range shrinks: clamp without a wrap.
      count_d = max_val;
    end else if (count_q == '0) begin
      count_d = max_val;
      tc_d    = 1'b1;
      if (wraps_q != {TALLY_W{1'b1}}) begin
        wraps_d = wraps_q + 1'b1;
      end
    end else begin
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      wraps_q <= '0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      wraps_q <= wraps_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.wraps = wraps_q;

endmodule

// File: tb/tb_mod_down_counter.sv
// Directed, table-driven bench for mod_down_counter with hand-written
// sequences for asynchronous reset, hold mode and tally saturation.
module tb_mod_down_counter;

  localparam int WIDTH   = 4;
  localparam int TALLY_W = 8;

  typedef struct {
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [1:0]       select;
    logic             enable;
    int               exp_count;
    int               exp_tc;
    int               exp_wraps;
  } vec_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  mod_down_counter_if #(.WIDTH(WIDTH), .TALLY_W(TALLY_W)) bus ();

  mod_down_counter #(.WIDTH(WIDTH), .TALLY_W(TALLY_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive inputs, take one rising edge, then settle 1 time unit past it.
  task automatic apply(input logic ld, input logic [WIDTH-1:0] lv,
                       input logic [1:0] sel, input logic en);
    bus.load     = ld;
    bus.load_val = lv;
    bus.select   = sel;
    bus.enable   = en;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string name, input int c, input int t, input int w);
    check({name, ".count"}, int'(bus.count), c);
    check({name, ".tc"},    int'(bus.tc),    t);
    check({name, ".wraps"}, int'(bus.wraps), w);
  endtask

  vec_t vecs[26];

  initial begin
    errors = 0;
    checks = 0;

    //           load val    sel    en   cnt tc wr
    vecs[0]  = '{1'b1, 4'd2,  2'b01, 1'b1, 2, 0, 0};  // load beats enable
    vecs[1]  = '{1'b0, 4'd0,  2'b01, 1'b1, 1, 0, 0};
    vecs[2]  = '{1'b0, 4'd0,  2'b01, 1'b1, 0, 0, 0};
    vecs[3]  = '{1'b0, 4'd0,  2'b01, 1'b1, 3, 1, 1};  // mod-4 wrap
    vecs[4]  = '{1'b0, 4'd0,  2'b01, 1'b1, 2, 0, 1};
    vecs[5]  = '{1'b0, 4'd0,  2'b01, 1'b1, 1, 0, 1};
    vecs[6]  = '{1'b0, 4'd0,  2'b01, 1'b1, 0, 0, 1};
    vecs[7]  = '{1'b1, 4'd13, 2'b11, 1'b0, 13, 0, 0};
    vecs[8]  = '{1'b0, 4'd0,  2'b10, 1'b1, 7, 0, 0};  // clamp on range shrink
    vecs[9]  = '{1'b0, 4'd0,  2'b10, 1'b1, 6, 0, 0};
    vecs[10] = '{1'b0, 4'd0,  2'b10, 1'b1, 5, 0, 0};
    vecs[11] = '{1'b0, 4'd0,  2'b10, 1'b1, 4, 0, 0};
    vecs[12] = '{1'b0, 4'd0,  2'b10, 1'b1, 3, 0, 0};
    vecs[13] = '{1'b0, 4'd0,  2'b10, 1'b1, 2, 0, 0};
    vecs[14] = '{1'b0, 4'd0,  2'b10, 1'b1, 1, 0, 0};
    vecs[15] = '{1'b0, 4'd0,  2'b10, 1'b1, 0, 0, 0};
    vecs[16] = '{1'b0, 4'd0,  2'b10, 1'b1, 7, 1, 1};  // mod-8 wrap
    vecs[17] = '{1'b0, 4'd0,  2'b10, 1'b1, 6, 0, 1};
    vecs[18] = '{1'b0, 4'd0,  2'b10, 1'b1, 5, 0, 1};
    vecs[19] = '{1'b0, 4'd0,  2'b10, 1'b1, 4, 0, 1};
    vecs[20] = '{1'b0, 4'd0,  2'b10, 1'b1, 3, 0, 1};
    vecs[21] = '{1'b0, 4'd0,  2'b10, 1'b1, 2, 0, 1};
    vecs[22] = '{1'b0, 4'd0,  2'b10, 1'b1, 1, 0, 1};
    vecs[23] = '{1'b0, 4'd0,  2'b10, 1'b1, 0, 0, 1};
    vecs[24] = '{1'b1, 4'd12, 2'b10, 1'b1, 4, 0, 0};  // load vs wrap collision
    vecs[25] = '{1'b0, 4'd0,  2'b10, 1'b0, 4, 0, 0};  // enable low holds

    // Reset state
    rst_n        = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = '0;
    bus.select   = 2'b00;
    bus.enable   = 1'b0;
    #12;
    check_outputs("reset", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++) begin
      apply(vecs[i].load, vecs[i].load_val, vecs[i].select, vecs[i].enable);
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_tc, vecs[i].exp_wraps);
    end

    // Hold mode ignores enable for ten edges.
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 4'd0, 2'b00, 1'b1);
      check($sformatf("hold%0d.count", i), int'(bus.count), 4);
      check($sformatf("hold%0d.tc", i), int'(bus.tc), 0);
    end
    apply(1'b1, 4'd9, 2'b00, 1'b1);
    check_outputs("hold_load", 9, 0, 0);

    // Asynchronous reset asserted between edges while count=5.
    apply(1'b1, 4'd5, 2'b11, 1'b0);
    check_outputs("pre_reset", 5, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check_outputs("async_reset", 0, 0, 0);
    bus.load   = 1'b0;
    bus.select = 2'b01;
    bus.enable = 1'b1;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("post_reset", 3, 1, 1);

    // Tally saturation: from count=3, wraps=1 every 4th edge wraps again.
    for (int k = 1; k <= 1100; k++) begin
      int exp_w;
      apply(1'b0, 4'd0, 2'b01, 1'b1);
      exp_w = 1 + k / 4;
      if (exp_w > 255) exp_w = 255;
      check($sformatf("sat%0d.count", k), int'(bus.count), 3 - (k % 4));
      check($sformatf("sat%0d.tc", k), int'(bus.tc), (k % 4 == 0) ? 1 : 0);
      check($sformatf("sat%0d.wraps", k), int'(bus.wraps), exp_w);
    end
    check("sat_final.wraps", int'(bus.wraps), 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
